// File: rtl/qpsk_pkg.sv
// qpsk_pkg: shared types and default sizing for the QPSK symbol sequencer.
package qpsk_pkg;
    localparam int DEF_SAMPLES_PER_SYM = 100;
    localparam int DEF_DIV             = 16;
    localparam int DEF_FIFO_DEPTH      = 4;

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic e;
        logic o;
    } sym_t;
endpackage

// File: rtl/qpsk_sym_fifo.sv
// qpsk_sym_fifo: first-word-fall-through FIFO of 2-bit symbols with level, full and empty.
module qpsk_sym_fifo
    import qpsk_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic [1:0]  din_i,
    output logic [1:0]  dout_o,
    output logic [AW:0] level_o,
    output logic        full_o,
    output logic        empty_o
);
    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   level_q, level_d;
    logic          do_push, do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign level_d = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    assign full_o  = level_q == (AW+1)'(DEPTH);
    assign empty_o = level_q == '0;
    assign dout_o  = mem[rd_q];
    assign level_o = level_q;

    always_ff @(posedge Clk) begin
        if (do_push) mem[wr_q] <= din_i;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_q + AW'(do_push);
            rd_q    <= rd_q + AW'(do_pop);
            level_q <= level_d;
        end
    end
endmodule

// File: rtl/qpsk_symbol_sequencer.sv
// qpsk_symbol_sequencer: pairs serial bits into (E,O) symbols, buffers them and
// paces each one over SAMPLES_PER_SYM carrier samples of the LUT modulator.
module qpsk_symbol_sequencer
    import qpsk_pkg::*;
#(
    parameter int DIV             = DEF_DIV,
    parameter int SAMPLES_PER_SYM = DEF_SAMPLES_PER_SYM,
    parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
    parameter int PHASE_W         = $clog2(SAMPLES_PER_SYM)
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          en,
    input  logic                          bit_in,
    input  logic                          bit_valid,
    output logic                          bit_ready,
    output logic                          sym_e,
    output logic                          sym_o,
    output logic [PHASE_W-1:0]            phase_idx,
    output logic                          sample_en,
    output logic                          sym_start,
    output logic                          active,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int DW = $clog2(DIV);

    logic [DW-1:0]      div_q, div_d;
    logic               half_q, e_q, accept, push, pop, full, empty, last_phase;
    logic [1:0]         head;
    sym_t               sym_q;
    state_t             state_q;
    logic [PHASE_W-1:0] phase_q;
    logic               start_q, under_q, active_q;

    assign sample_en  = en && !Rst && div_q == DW'(DIV - 1);
    assign div_d      = !en ? div_q : (div_q == DW'(DIV - 1) ? '0 : div_q + 1'b1);
    assign bit_ready  = !full && !Rst;
    assign accept     = bit_valid && bit_ready;
    assign push       = accept && half_q;
    assign last_phase = phase_q == PHASE_W'(SAMPLES_PER_SYM - 1);
    // Emptiness is judged on the registered level, so a same-cycle push never feeds this pop.
    assign pop        = sample_en && !empty && (state_q == IDLE || last_phase);

    qpsk_sym_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .Clk     (Clk),
        .Rst     (Rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   ({e_q, bit_in}),
        .dout_o  (head),
        .level_o (fifo_level),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            div_q  <= '0;
            half_q <= 1'b0;
            e_q    <= 1'b0;
        end else begin
            div_q <= div_d;
            if (accept) begin
                half_q <= !half_q;
                if (!half_q) e_q <= bit_in;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            sym_q    <= '0;
            start_q  <= 1'b0;
            under_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            under_q <= 1'b0;
            if (pop) begin
                sym_q    <= head;
                phase_q  <= '0;
                start_q  <= 1'b1;
                active_q <= 1'b1;
                state_q  <= RUN;
            end else if (sample_en && state_q == RUN && !last_phase) begin
                phase_q <= phase_q + 1'b1;
            end else if (sample_en && state_q == RUN) begin
                under_q  <= 1'b1;
                active_q <= 1'b0;
                phase_q  <= '0;
                state_q  <= IDLE;
            end
        end
    end

    assign sym_e     = sym_q.e;
    assign sym_o     = sym_q.o;
    assign phase_idx = phase_q;
    assign sym_start = start_q;
    assign underrun  = under_q;
    assign active    = active_q;
endmodule

// File: tb/tb_qpsk_symbol_sequencer.sv
// tb_qpsk_symbol_sequencer: directed plan plus random traffic against a queue-based symbol model.
module tb_qpsk_symbol_sequencer;
    localparam int DIV = 16;
    localparam int SPS = 100;
    localparam int FD  = 4;

    logic       Clk = 1'b0, Rst = 1'b1, en = 1'b0, bit_in = 1'b0, bit_valid = 1'b0;
    logic       bit_ready, sym_e, sym_o, sample_en, sym_start, active, underrun;
    logic [6:0] phase_idx;
    logic [2:0] fifo_level;

    int n_tests = 0, n_fail = 0, cyc = 0, n_start = 0, n_under = 0, last_start = 0;
    int gaps[$];
    bit chk_on = 1'b0;

    // Reference model: en-cycle count, bit queue pairing, and samples elapsed in the current symbol.
    int         m_en_cnt = 0, m_k = -1;
    bit         m_has_half = 1'b0, m_hb = 1'b0;
    logic [1:0] m_q[$];
    bit         m_e = 0, m_o = 0, m_start = 0, m_under = 0;

    qpsk_symbol_sequencer #(.DIV(DIV), .SAMPLES_PER_SYM(SPS), .FIFO_DEPTH(FD), .PHASE_W(7)) dut (
        .Clk(Clk), .Rst(Rst), .en(en), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .sym_e(sym_e), .sym_o(sym_o), .phase_idx(phase_idx),
        .sample_en(sample_en), .sym_start(sym_start), .active(active),
        .underrun(underrun), .fifo_level(fifo_level)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(posedge Clk) begin
        bit samp, acc;
        cyc++;
        if (Rst) begin
            m_en_cnt = 0; m_k = -1; m_has_half = 0; m_q.delete();
            m_e = 0; m_o = 0; m_start = 0; m_under = 0;
        end else begin
            samp = en && (m_en_cnt % DIV == DIV - 1);
            acc  = bit_valid && m_q.size() < FD;
            m_start = 0; m_under = 0;
            if (samp) begin
                if (m_k < 0 || m_k == SPS - 1) begin
                    if (m_q.size() > 0) begin
                        {m_e, m_o} = m_q.pop_front();
                        m_k = 0; m_start = 1;
                    end else begin
                        if (m_k == SPS - 1) m_under = 1;
                        m_k = -1;
                    end
                end else m_k++;
            end
            if (acc) begin
                if (!m_has_half) begin m_hb = bit_in; m_has_half = 1; end
                else begin m_q.push_back({m_hb, bit_in}); m_has_half = 0; end
            end
            if (en) m_en_cnt++;
        end
    end

    always @(negedge Clk) begin
        #1;
        if (chk_on) begin
            check("sample_en", sample_en, int'(en && !Rst && (m_en_cnt % DIV == DIV - 1)));
            check("bit_ready", bit_ready, int'(!Rst && m_q.size() < FD));
            check("sym_e", sym_e, m_e);
            check("sym_o", sym_o, m_o);
            check("phase_idx", phase_idx, m_k < 0 ? 0 : m_k);
            check("sym_start", sym_start, m_start);
            check("underrun", underrun, m_under);
            check("active", active, int'(m_k >= 0));
            check("fifo_level", fifo_level, m_q.size());
            if (sym_start) begin
                n_start++;
                gaps.push_back(cyc - last_start);
                last_start = cyc;
            end
            if (underrun) n_under++;
        end
    end

    task automatic send_bit(input logic b);
        bit_in = b; bit_valid = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            #1;
            if (bit_ready) begin @(negedge Clk); bit_valid = 1'b0; return; end
            @(negedge Clk);
        end
        check("send_timeout", 0, 1);
        bit_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < 4000; i++) begin
            @(negedge Clk); #1;
            if (active && phase_idx == 7'(p)) return;
        end
        check("wait_phase_timeout", 0, 1);
    endtask

    task automatic wait_start();
        for (int i = 0; i < 4000; i++) begin
            @(negedge Clk); #1;
            if (sym_start) return;
        end
        check("wait_start_timeout", 0, 1);
    endtask

    initial begin
        int s0, u0;
        logic [7:0] pre;
        // Reset held with a valid bit offered.
        bit_valid = 1'b1; bit_in = 1'b1;
        @(negedge Clk);
        chk_on = 1'b1;
        wait_cycles(2);
        check("rst_level", fifo_level, 0);
        Rst = 1'b0; bit_valid = 1'b0; en = 1'b1;
        // Single symbol 1,0 then underrun.
        s0 = n_start; u0 = n_under;
        send_bit(1'b1); send_bit(1'b0);
        wait_start();
        check("t2_e", sym_e, 1);
        check("t2_o", sym_o, 0);
        wait_cycles(SPS * DIV + 40);
        check("t2_starts", n_start - s0, 1);
        check("t2_unders", n_under - u0, 1);
        check("t2_active", active, 0);
        // Back-to-back: preload 11 00 10 01 with en low.
        en = 1'b0;
        pre = 8'b11001001;
        for (int i = 7; i >= 0; i--) send_bit(pre[i]);
        check("t3_level", fifo_level, 4);
        s0 = n_start; u0 = n_under;
        gaps.delete();
        en = 1'b1;
        wait_cycles(4 * SPS * DIV + 60);
        check("t3_starts", n_start - s0, 4);
        check("t3_unders", n_under - u0, 1);
        check("t3_ngaps", gaps.size(), 4);
        for (int i = 1; i < gaps.size(); i++) check("t3_gap", gaps[i], SPS * DIV);
        // Full: 8 bits accepted, 9th held off.
        en = 1'b0;
        for (int i = 0; i < 8; i++) send_bit(1'(i));
        bit_in = 1'b1; bit_valid = 1'b1;
        wait_cycles(20); #1;
        check("t4_ready", bit_ready, 0);
        check("t4_level", fifo_level, 4);
        en = 1'b1;
        send_bit(1'b1); send_bit(1'b0);
        wait_cycles(6 * SPS * DIV);
        // Freeze at phase 37.
        send_bit(1'b0); send_bit(1'b0);
        wait_phase(37);
        en = 1'b0;
        wait_cycles(50); #1;
        check("t5_phase_hold", phase_idx, 37);
        check("t5_no_sample", sample_en, 0);
        en = 1'b1;
        wait_phase(38);
        check("t5_resume", phase_idx, 38);
        wait_cycles(SPS * DIV);
        // Odd bit then reset discards the half pair.
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        Rst = 1'b1;
        wait_cycles(2);
        Rst = 1'b0;
        send_bit(1'b0); send_bit(1'b1);
        wait_start();
        check("t6_e", sym_e, 0);
        check("t6_o", sym_o, 1);
        wait_cycles(SPS * DIV + 40);
        // Random traffic with occasional en drops and resets.
        for (int i = 0; i < 8000; i++) begin
            bit_in    = 1'($urandom);
            bit_valid = $urandom_range(0, 2) == 0;
            en        = $urandom_range(0, 9) != 0;
            Rst       = $urandom_range(0, 1999) == 0;
            @(negedge Clk);
        end
        Rst = 1'b0; bit_valid = 1'b0;
        wait_cycles(4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/qpsk_symbol_sequencer.md
Name: qpsk_symbol_sequencer

Overview:
Controller that feeds the QPSK carrier LUT modulator. It accepts a serial bit stream over a valid/ready handshake and pairs the bits into (E, O) symbols. Symbols are buffered in a small FIFO. The block generates the divided sample strobe and the LUT phase index, and holds each symbol for exactly SAMPLES_PER_SYM samples. It sits between the bit source and the modulator, replacing the free-running divider and the free-running index inside the modulator.

Parameters:
DIV, 16, Clk cycles per carrier sample; must be >= 2.
SAMPLES_PER_SYM, 100, LUT samples per symbol; the phase index runs 0..SAMPLES_PER_SYM-1.
FIFO_DEPTH, 4, symbol FIFO entries; must be a power of 2 and >= 2.
PHASE_W, 7, width of phase_idx; equals clog2(SAMPLES_PER_SYM).

Ports:
Clk  in  1  system clock; all logic is on the rising edge.
Rst  in  1  synchronous, active-high reset.
en  in  1  run enable; when low, the sample divider and phase index freeze.
bit_in  in  1  serial data bit.
bit_valid  in  1  bit_in is valid.
bit_ready  out  1  the block accepts bit_in this cycle.
sym_e  out  1  E (in-phase) select for the modulator.
sym_o  out  1  O (quadrature) select for the modulator.
phase_idx  out  PHASE_W  LUT read index.
sample_en  out  1  one-cycle strobe; the modulator samples the LUT at this strobe.
sym_start  out  1  one-cycle pulse when a new symbol is loaded (phase_idx = 0).
active  out  1  a symbol is being transmitted.
underrun  out  1  one-cycle pulse when a symbol ends and the FIFO is empty.
fifo_level  out  clog2(FIFO_DEPTH)+1  number of buffered symbols.

Behaviour:
Reset (synchronous, Rst=1 at a Clk edge):
- All outputs are 0 and state is IDLE.
- Divider = 0, FIFO empty, pair latch empty.
- Reset mid-symbol discards the current symbol, the buffered symbols and any half-pair.

Divider:
- While en=1, div_cnt counts 0..DIV-1 and wraps.
- sample_en=1 in the cycle where div_cnt==DIV-1 and en=1.
- While en=0, div_cnt holds and sample_en=0.

Bit intake:
- A bit is accepted when bit_valid && bit_ready.
- bit_ready = (fifo_level < FIFO_DEPTH) && !Rst.
- The first accepted bit is latched as E and the half flag is set.
- The second accepted bit is O; {E,O} is pushed into the FIFO in that cycle and the half flag is cleared.
- The half-pair persists across en=0.

FIFO:
- Synchronous, first-word fall-through.
- A push and a pop in the same cycle leaves the level unchanged.
- No push ever occurs when full, because ready is deasserted.

Scheduler FSM (states IDLE, RUN); all transitions are taken only on sample_en cycles:
- IDLE, FIFO non-empty: pop the symbol, drive sym_e/sym_o, phase_idx=0, sym_start=1, active=1, go to RUN.
- IDLE, FIFO empty: stay in IDLE; active=0, phase_idx=0, sym_e/sym_o hold their last values.
- RUN, phase_idx < SAMPLES_PER_SYM-1: increment phase_idx.
- RUN, phase_idx == SAMPLES_PER_SYM-1, FIFO non-empty: pop, load the new symbol, phase_idx=0, sym_start=1, stay in RUN. There is no gap between symbols.
- RUN, phase_idx == SAMPLES_PER_SYM-1, FIFO empty: underrun=1, active=0, phase_idx=0, go to IDLE.
- A symbol pushed in the same cycle as the boundary sample_en does not count as available; the FIFO is checked before the push. This is an underrun.

Timing and arithmetic:
- Outputs are registered; sym_e, sym_o, phase_idx and active update one cycle after the sample_en cycle.
- Latency: the first symbol starts at the first sample_en after the cycle in which its second bit is accepted.
- phase_idx never exceeds SAMPLES_PER_SYM-1; all counters are unsigned.

Decomposition:
Package qpsk_pkg holds:
- The state enum (IDLE, RUN).
- Default constants: SAMPLES_PER_SYM=100, DIV=16, FIFO_DEPTH=4.
- A symbol struct {e, o}.

One sub-module, qpsk_sym_fifo: a parameterised 2-bit-wide first-word-fall-through FIFO with push, pop, level, full and empty. The divider, pair latch and FSM stay in the top module.

Test Plan:
1. Reset: hold Rst for 3 cycles with bit_valid=1 -> all outputs 0, bit_ready=0 during reset, and no bit is accepted.
2. Single symbol: with DIV=16 and en=1, send bits 1,0 -> at the next sample_en, sym_start=1, sym_e=1, sym_o=0, active=1. phase_idx steps 0..99, once per 16 cycles. After sample 99, underrun=1, active=0 and the FSM is in IDLE.
3. Back-to-back: pre-load 4 symbols (bits 11 00 10 01) -> four sym_start pulses exactly 1600 cycles apart, symbols in order, no underrun until the 4th symbol ends. fifo_level steps 4→3→2→1→0.
4. Full: with en=0, stream 10 bits -> bit_ready drops after the 8th bit and fifo_level=4. The 9th bit is held by the source and is not accepted.
5. Freeze: drop en mid-symbol at phase_idx=37 for 50 cycles -> no sample_en and phase_idx stays 37. When en returns, counting resumes at 38 and div_cnt continues from its held value.
6. Odd bit and reset: send 3 bits, then assert Rst -> the half-pair is discarded, and after reset bits 0,1 produce sym_e=0, sym_o=1.
